imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_if.sv | 37 +++
 rtl/imem_loader.sv | 220 ++++++++++++++++++++++
 tb/tb_imem_loader.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// ============================================================================
// Module   : imem_loader_if
// Purpose  : UART byte stream, response channel and instruction-RAM write port
//            shared between the image loader and its surroundings.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface imem_loader_if #(
    parameter int ADDR_WIDTH = 8
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic [7:0]            tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;
    logic                  cpu_hold;
    logic                  load_done;
    logic                  load_error;

    modport master (
        input  rx_data, rx_valid, tx_ready,
        output tx_data, tx_valid, imem_we, imem_addr, imem_wdata,
               cpu_hold, load_done, load_error
    );

    modport slave (
        output rx_data, rx_valid, tx_ready,
        input  tx_data, tx_valid, imem_we, imem_addr, imem_wdata,
               cpu_hold, load_done, load_error
    );
endinterface

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module   : imem_loader
// Purpose  : Receives a framed program image over UART bytes, writes it into
//            instruction RAM and answers ACK/NAK; holds the CPU meanwhile.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = 50000
) (
    input  wire logic        clk,
    input  wire logic        reset,
    imem_loader_if.master    bus
);
    localparam logic [7:0] C_SYNC = 8'hA5;
    localparam logic [7:0] C_ACK  = 8'h06;
    localparam logic [7:0] C_NAK  = 8'h15;
    localparam int         C_TW   = $clog2(TIMEOUT + 1);
    localparam int         C_PW   = ADDR_WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CNT_HI = 3'd1,
        S_CNT_LO = 3'd2,
        S_DATA   = 3'd3,
        S_CSUM   = 3'd4,
        S_RESP   = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [7:0]            cnt_hi_q, cnt_hi_d;
    logic [15:0]           count_q, count_d;
    logic [23:0]           word_q, word_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [C_PW-1:0]       ptr_q, ptr_d;
    logic [7:0]            csum_q, csum_d;
    logic [C_TW-1:0]       idle_q, idle_d;
    logic                  imem_we_q, imem_we_d;
    logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]           imem_wdata_q, imem_wdata_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  tx_valid_q, tx_valid_d;
    logic                  load_done_q, load_done_d;
    logic                  load_error_q, load_error_d;
    logic                  cpu_hold_q, cpu_hold_d;

    logic                  w_active;
    logic                  w_timeout;
    logic [15:0]           w_n;
    logic [C_PW-1:0]       w_ptr_next;

    always_comb begin
        state_d      = state_q;
        cnt_hi_d     = cnt_hi_q;
        count_d      = count_q;
        word_d       = word_q;
        byte_idx_d   = byte_idx_q;
        ptr_d        = ptr_q;
        csum_d       = csum_q;
        idle_d       = idle_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = tx_valid_q;
        load_done_d  = 1'b0;
        load_error_d = load_error_q;
        cpu_hold_d   = cpu_hold_q;
        w_timeout    = 1'b0;
        w_n          = {cnt_hi_q, bus.rx_data};
        w_ptr_next   = ptr_q + C_PW'(1);

        // Inter-byte watchdog; a byte arriving on the expiry cycle still wins.
        w_active = (state_q == S_CNT_HI) || (state_q == S_CNT_LO) ||
                   (state_q == S_DATA)   || (state_q == S_CSUM);
        if (w_active) begin
            if (bus.rx_valid) begin
                idle_d = '0;
            end else if (idle_q == C_TW'(TIMEOUT - 1)) begin
                w_timeout = 1'b1;
            end else begin
                idle_d = idle_q + C_TW'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (bus.rx_valid && bus.rx_data == C_SYNC) begin
                    state_d      = S_CNT_HI;
                    cpu_hold_d   = 1'b1;
                    load_error_d = 1'b0;
                    idle_d       = '0;
                end
            end
            S_CNT_HI: begin
                if (bus.rx_valid) begin
                    cnt_hi_d = bus.rx_data;
                    state_d  = S_CNT_LO;
                end
            end
            S_CNT_LO: begin
                if (bus.rx_valid) begin
                    count_d = w_n;
                    if (w_n == 16'd0 || 32'(w_n) > (32'd1 << ADDR_WIDTH)) begin
                        state_d      = S_RESP;
                        tx_data_d    = C_NAK;
                        tx_valid_d   = 1'b1;
                        load_error_d = 1'b1;
                    end else begin
                        state_d    = S_DATA;
                        ptr_d      = '0;
                        byte_idx_d = '0;
                        csum_d     = '0;
                    end
                end
            end
            S_DATA: begin
                if (bus.rx_valid) begin
                    word_d     = {word_q[15:0], bus.rx_data};
                    csum_d     = csum_q ^ bus.rx_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = ptr_q[ADDR_WIDTH-1:0];
                        imem_wdata_d = {word_q, bus.rx_data};
                        ptr_d        = w_ptr_next;
                        if (32'(w_ptr_next) == 32'(count_q)) begin
                            state_d = S_CSUM;
                        end
                    end
                end
            end
            S_CSUM: begin
                if (bus.rx_valid) begin
                    state_d    = S_RESP;
                    tx_valid_d = 1'b1;
                    if (bus.rx_data == csum_q) begin
                        tx_data_d = C_ACK;
                    end else begin
                        tx_data_d    = C_NAK;
                        load_error_d = 1'b1;
                    end
                end
            end
            S_RESP: begin
                if (tx_valid_q && bus.tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = S_IDLE;
                    if (tx_data_q == C_ACK) begin
                        load_done_d = 1'b1;
                        cpu_hold_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (w_timeout) begin
            state_d      = S_RESP;
            tx_data_d    = C_NAK;
            tx_valid_d   = 1'b1;
            load_error_d = 1'b1;
            idle_d       = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_hi_q     <= '0;
            count_q      <= '0;
            word_q       <= '0;
            byte_idx_q   <= '0;
            ptr_q        <= '0;
            csum_q       <= '0;
            idle_q       <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
            cpu_hold_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_hi_q     <= cnt_hi_d;
            count_q      <= count_d;
            word_q       <= word_d;
            byte_idx_q   <= byte_idx_d;
            ptr_q        <= ptr_d;
            csum_q       <= csum_d;
            idle_q       <= idle_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            load_done_q  <= load_done_d;
            load_error_q <= load_error_d;
            cpu_hold_q   <= cpu_hold_d;
        end
    end

    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.tx_valid   = tx_valid_q;
    assign bus.load_done  = load_done_q;
    assign bus.load_error = load_error_q;
    assign bus.cpu_hold   = cpu_hold_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module   : tb_imem_loader
// Purpose  : Randomized frame-level checking of imem_loader against a model
//            of the frame rules (writes, latency, response, flags).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;
    localparam int C_AW = 8;
    localparam int C_TO = 64;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        int          c;
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_WIDTH(C_AW)) bus ();

    imem_loader #(.ADDR_WIDTH(C_AW), .TIMEOUT(C_TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    int  total = 0;
    int  bad = 0;
    int  cyc = 0;
    int  last_cyc = 0;
    int  done_cnt = 0;
    wr_t wr_q[$];
    int  exp_cyc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Edge counter plus write/done monitor, sampled just after each edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (bus.imem_we === 1'b1) wr_q.push_back('{c: cyc, a: 32'(bus.imem_addr), d: bus.imem_wdata});
        if (bus.load_done === 1'b1) done_cnt++;
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        last_cyc     = cyc + 1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_we"},   32'(bus.imem_we), 32'd0);
        chk({tag, "_addr"}, 32'(bus.imem_addr), 32'd0);
        chk({tag, "_wdat"}, bus.imem_wdata, 32'd0);
        chk({tag, "_txv"},  32'(bus.tx_valid), 32'd0);
        chk({tag, "_txd"},  32'(bus.tx_data), 32'd0);
        chk({tag, "_done"}, 32'(bus.load_done), 32'd0);
        chk({tag, "_err"},  32'(bus.load_error), 32'd0);
        chk({tag, "_hold"}, 32'(bus.cpu_hold), 32'd0);
    endtask

    // Drives one frame and checks it against the frame rules.
    task automatic frame(input logic [15:0] n, input bq_t data, input logic [7:0] cmask,
                         input bit tmo, input int bp, input int maxgap);
        bit          valid, ack;
        logic [7:0]  x, t;
        int          nwr, w, done0;
        logic [31:0] word;
        wr_q.delete();
        exp_cyc.delete();
        done0 = done_cnt;
        valid = (n != 16'd0) && (int'(n) <= (1 << C_AW));
        x = 8'h00;
        repeat ($urandom_range(0, 2)) begin
            t = 8'($urandom);
            send_byte((t == 8'hA5) ? 8'h5A : t, $urandom_range(0, maxgap));
        end
        send_byte(8'hA5, $urandom_range(0, maxgap));
        send_byte(n[15:8], $urandom_range(0, maxgap));
        send_byte(n[7:0], $urandom_range(0, maxgap));
        if (valid) begin
            for (int i = 0; i < data.size(); i++) begin
                send_byte(data[i], $urandom_range(0, maxgap));
                x = x ^ data[i];
                if (i % 4 == 3) exp_cyc.push_back(last_cyc);
            end
            if (!tmo) send_byte(x ^ cmask, $urandom_range(0, maxgap));
        end
        ack = valid && !tmo && (cmask == 8'h00) && (data.size() == 4 * int'(n));

        w = 0;
        while (bus.tx_valid !== 1'b1 && w < C_TO + 20) begin
            @(negedge clk);
            w++;
        end
        chk("resp_valid", 32'(bus.tx_valid), 32'd1);
        if (tmo) chk("tmo_latency", 32'(cyc - last_cyc), 32'(C_TO));
        chk("resp_byte", 32'(bus.tx_data), ack ? 32'h06 : 32'h15);
        chk("err_flag", 32'(bus.load_error), ack ? 32'd0 : 32'd1);
        chk("hold_in_resp", 32'(bus.cpu_hold), 32'd1);

        // Backpressure with stray receive traffic that must be ignored.
        t = bus.tx_data;
        for (int k = 0; k < bp; k++) begin
            bus.rx_valid = 1'($urandom);
            bus.rx_data  = 8'($urandom);
            @(negedge clk);
            chk("bp_valid", 32'(bus.tx_valid), 32'd1);
            chk("bp_data", 32'(bus.tx_data), 32'(t));
        end
        bus.rx_valid = 1'b0;

        nwr = valid ? data.size() / 4 : 0;
        chk("wr_count", 32'(wr_q.size()), 32'(nwr));
        for (int i = 0; i < nwr && i < wr_q.size(); i++) begin
            word = {data[4*i], data[4*i+1], data[4*i+2], data[4*i+3]};
            chk("wr_addr", wr_q[i].a, 32'(i));
            chk("wr_data", wr_q[i].d, word);
            chk("wr_latency", 32'(wr_q[i].c), 32'(exp_cyc[i]));
        end

        bus.tx_ready = 1'b1;
        @(negedge clk);
        bus.tx_ready = 1'b0;
        chk("hs_txv_low", 32'(bus.tx_valid), 32'd0);
        chk("hs_done", 32'(bus.load_done), ack ? 32'd1 : 32'd0);
        chk("hs_hold", 32'(bus.cpu_hold), ack ? 32'd0 : 32'd1);
        @(negedge clk);
        chk("done_pulses", 32'(done_cnt - done0), ack ? 32'd1 : 32'd0);
        chk("done_one_cycle", 32'(bus.load_done), 32'd0);
    endtask

    function automatic bq_t rand_data(input int words);
        bq_t q;
        for (int i = 0; i < 4 * words; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    initial begin
        bq_t d, empty;
        int  nw;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        reset = 1'b1;
        @(negedge clk);

        // Good two-word load, then the same image with a corrupted checksum.
        d = '{8'h24, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};
        frame(16'd2, d, 8'h00, 1'b0, 0, 0);
        frame(16'd2, d, 8'h0D, 1'b0, 0, 0);

        // Count bounds.
        frame(16'h0101, empty, 8'h00, 1'b0, 0, 1);
        frame(16'h0000, empty, 8'h00, 1'b0, 0, 1);

        // Stall after two data bytes, then a clean reload.
        d = '{8'h11, 8'h22};
        frame(16'd4, d, 8'h00, 1'b1, 0, 0);
        frame(16'd3, rand_data(3), 8'h00, 1'b0, 0, 2);

        // Long response backpressure.
        frame(16'd1, rand_data(1), 8'h00, 1'b0, 20, 1);

        // Largest legal image.
        frame(16'd256, rand_data(256), 8'h00, 1'b0, 1, 0);

        for (int r = 0; r < 12; r++) begin
            nw = $urandom_range(1, 6);
            frame(16'(nw), rand_data(nw),
                  ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
                  1'b0, $urandom_range(0, 4), 3);
        end

        // Reset in the middle of the data phase.
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        for (int i = 0; i < 6; i++) send_byte(8'h30 + 8'(i), 0);
        reset = 1'b0;
        @(negedge clk);
        chk_zero_outputs("midreset");
        reset = 1'b1;
        wr_q.delete();
        for (int i = 0; i < 10; i++) send_byte(8'h40 + 8'(i), 0);
        repeat (5) @(negedge clk);
        chk("midreset_writes", 32'(wr_q.size()), 32'd0);
        chk("midreset_txv", 32'(bus.tx_valid), 32'd0);
        chk("midreset_hold", 32'(bus.cpu_hold), 32'd0);
        frame(16'd2, rand_data(2), 8'h00, 1'b0, 2, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
